// File: rtl/m20k_fifo_controller_if.sv
// ---------------------------------------------------------------------------
// m20k_fifo_controller_if
// Bundles the push handshake, pop handshake, M20K port wiring and status
// outputs of the M20K FIFO controller.
//   master : the controller side (drives pushReady, pop side, memory ports,
//            count, eccError)
//   slave  : the surrounding producer / consumer / memory side
// Signals:
//   pushValid, pushData, pushReady      producer handshake
//   popValid, popData, popReady         consumer handshake
//   memWriteEnable, memWriteAddr,
//   memDataOut                          memory write port
//   memReadEnable, memReadAddr          memory read port
//   memDataIn, memEccStatus             memory read data / ECC status
//   count                               entries held (memory + in flight + skid)
//   eccError                            sticky ECC flag
// ---------------------------------------------------------------------------
interface m20k_fifo_controller_if #(
    parameter int WIDTH      = 20,
    parameter int DEPTH_LOG2 = 9
);
    logic                  pushValid;
    logic [WIDTH-1:0]      pushData;
    logic                  pushReady;
    logic                  popValid;
    logic [WIDTH-1:0]      popData;
    logic                  popReady;
    logic                  memWriteEnable;
    logic [DEPTH_LOG2-1:0] memWriteAddr;
    logic [WIDTH-1:0]      memDataOut;
    logic                  memReadEnable;
    logic [DEPTH_LOG2-1:0] memReadAddr;
    logic [WIDTH-1:0]      memDataIn;
    logic                  memEccStatus;
    logic [DEPTH_LOG2:0]   count;
    logic                  eccError;

    modport master (
        input  pushValid, pushData, popReady, memDataIn, memEccStatus,
        output pushReady, popValid, popData,
        output memWriteEnable, memWriteAddr, memDataOut,
        output memReadEnable, memReadAddr,
        output count, eccError
    );

    modport slave (
        output pushValid, pushData, popReady, memDataIn, memEccStatus,
        input  pushReady, popValid, popData,
        input  memWriteEnable, memWriteAddr, memDataOut,
        input  memReadEnable, memReadAddr,
        input  count, eccError
    );
endinterface

// File: rtl/m20k_fifo_controller.sv
// ---------------------------------------------------------------------------
// m20k_fifo_controller
// Runs a single-clock M20K block (registered read address, two output
// register stages, zero output when readEnable is low) as a first-word-
// fall-through FIFO. Pushes are written straight into the memory; reads are
// issued ahead of demand and their returning data lands in a small skid
// buffer whose head is presented on the pop port, hiding the read latency.
// Ports:
//   clk     in   single clock, all logic on posedge
//   rst_n   in   asynchronous assert, active-low reset
//   io_bus  master modport of m20k_fifo_controller_if (push/pop handshakes,
//           memory write/read ports, count, eccError)
// WRITE_TO_READ_DELAY must be at least 2.
// ---------------------------------------------------------------------------
module m20k_fifo_controller #(
    parameter int WIDTH               = 20,
    parameter int DEPTH_LOG2          = 9,
    parameter int READ_LATENCY        = 3,
    parameter int WRITE_TO_READ_DELAY = 2,
    parameter int SKID_DEPTH          = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    m20k_fifo_controller_if.master io_bus
);
    localparam int CNT_W      = DEPTH_LOG2 + 1;
    localparam int WTR_STAGES = WRITE_TO_READ_DELAY - 1;
    localparam int SKID_PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int FLIGHT_W   = $clog2(READ_LATENCY + 1);
    localparam int CRED_W     = SKID_CNT_W + 1;
    localparam logic [CNT_W-1:0] MEM_CAPACITY = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [CNT_W-1:0]      r_memUsed;
    logic [CNT_W-1:0]      r_readable;
    logic [WTR_STAGES-1:0] r_wtrPipe;
    logic                  r_pushReady;
    logic [READ_LATENCY-1:0] r_rdValid;
    logic [FLIGHT_W-1:0]   r_inFlight;
    logic [WIDTH-1:0]      r_skidMem [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] r_skidHead;
    logic [SKID_PTR_W-1:0] r_skidTail;
    logic [SKID_CNT_W-1:0] r_skidCount;
    logic [CNT_W-1:0]      r_count;
    logic                  r_eccError;

    logic                  w_pushFire;
    logic                  w_popFire;
    logic                  w_readIssue;
    logic                  w_capture;
    logic [CNT_W-1:0]      w_memUsedNext;
    logic [CRED_W-1:0]     w_creditUsed;

    function automatic logic [SKID_PTR_W-1:0] skidNext(input logic [SKID_PTR_W-1:0] ptr);
        return (ptr == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : ptr + SKID_PTR_W'(1);
    endfunction

    assign w_pushFire = io_bus.pushValid && r_pushReady;
    assign w_popFire  = (r_skidCount != '0) && io_bus.popReady;
    assign w_capture  = r_rdValid[READ_LATENCY-1];

    // Credit is what the skid would hold if every outstanding read landed:
    // reads in flight plus current skid entries, minus the head leaving this
    // cycle. Crediting the departing head is what lets a READ_LATENCY+1 deep
    // skid sustain one pop per cycle without ever overflowing.
    assign w_creditUsed = CRED_W'(r_inFlight) + CRED_W'(r_skidCount) - CRED_W'(w_popFire);
    assign w_readIssue  = (r_readable != '0) && (w_creditUsed < CRED_W'(SKID_DEPTH));

    assign w_memUsedNext = r_memUsed + CNT_W'(w_pushFire) - CNT_W'(w_readIssue);

    assign io_bus.pushReady      = r_pushReady;
    assign io_bus.memWriteEnable = w_pushFire;
    assign io_bus.memWriteAddr   = r_wrPtr;
    assign io_bus.memDataOut     = io_bus.pushData;
    assign io_bus.memReadEnable  = w_readIssue;
    assign io_bus.memReadAddr    = r_rdPtr;
    assign io_bus.popValid       = (r_skidCount != '0);
    assign io_bus.popData        = r_skidMem[r_skidHead];
    assign io_bus.count          = r_count;
    assign io_bus.eccError       = r_eccError;

    // Pointers, occupancy, the write-to-read delay line, the read-valid
    // shift register, the skid buffer and the status flags all advance
    // together here. A delay line of WRITE_TO_READ_DELAY-1 stages feeding the
    // readable counter makes a push in cycle t readable from cycle
    // t+WRITE_TO_READ_DELAY. Reset drops everything in flight, so any memory
    // data still returning afterwards is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_memUsed   <= '0;
            r_readable  <= '0;
            r_wtrPipe   <= '0;
            r_pushReady <= 1'b0;
            r_rdValid   <= '0;
            r_inFlight  <= '0;
            r_skidHead  <= '0;
            r_skidTail  <= '0;
            r_skidCount <= '0;
            r_count     <= '0;
            r_eccError  <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_skidMem[i] <= '0;
            end
        end else begin
            r_pushReady <= (w_memUsedNext < MEM_CAPACITY);
            r_memUsed   <= w_memUsedNext;

            if (w_pushFire) begin
                r_wrPtr <= r_wrPtr + DEPTH_LOG2'(1);
            end
            if (w_readIssue) begin
                r_rdPtr <= r_rdPtr + DEPTH_LOG2'(1);
            end

            r_wtrPipe[0] <= w_pushFire;
            for (int i = 1; i < WTR_STAGES; i++) begin
                r_wtrPipe[i] <= r_wtrPipe[i-1];
            end
            r_readable <= r_readable + CNT_W'(r_wtrPipe[WTR_STAGES-1]) - CNT_W'(w_readIssue);

            r_rdValid[0] <= w_readIssue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rdValid[i] <= r_rdValid[i-1];
            end
            r_inFlight <= r_inFlight + FLIGHT_W'(w_readIssue) - FLIGHT_W'(w_capture);

            if (w_capture) begin
                r_skidMem[r_skidTail] <= io_bus.memDataIn;
                r_skidTail            <= skidNext(r_skidTail);
            end
            if (w_popFire) begin
                r_skidHead <= skidNext(r_skidHead);
            end
            r_skidCount <= r_skidCount + SKID_CNT_W'(w_capture) - SKID_CNT_W'(w_popFire);

            r_count <= r_count + CNT_W'(w_pushFire) - CNT_W'(w_popFire);

            if (w_capture && io_bus.memEccStatus) begin
                r_eccError <= 1'b1;
            end
        end
    end

    // A capture into a full skid with no pop to make room would lose data.
    skidNoOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_capture && !w_popFire && (r_skidCount == SKID_CNT_W'(SKID_DEPTH))));

endmodule

// File: tb/tb_m20k_fifo_controller.sv
// ---------------------------------------------------------------------------
// tb_m20k_fifo_controller
// Drives m20k_fifo_controller against a behavioural M20K model (registered
// read address, two output stages, zero output when readEnable is low).
// Pushed words are queued as expected pop data; a negedge process pops and
// compares whenever the consumer handshake fires.
// ---------------------------------------------------------------------------
module tb_m20k_fifo_controller;
    localparam int WIDTH      = 20;
    localparam int DEPTH_LOG2 = 9;

    logic clk;
    logic rst_n;

    m20k_fifo_controller_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

    m20k_fifo_controller #(
        .WIDTH(WIDTH),
        .DEPTH_LOG2(DEPTH_LOG2),
        .READ_LATENCY(3),
        .WRITE_TO_READ_DELAY(2),
        .SKID_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io_bus(bus)
    );

    int               assertCount = 0;
    int               failCount   = 0;
    int               tbCount     = 0;
    logic [WIDTH-1:0] sbQueue[$];
    logic [WIDTH-1:0] expData;
    logic             eccArmed    = 1'b0;

    logic [WIDTH-1:0] memArray [1 << DEPTH_LOG2];
    logic [WIDTH-1:0] rdStage  [3];
    logic             eccStage [3];

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: write on the clock, read address registered, then two
    // output register stages. ECC status rides alongside the read data and
    // is raised for reads issued while eccArmed is set.
    always @(posedge clk) begin
        if (bus.memWriteEnable) begin
            memArray[bus.memWriteAddr] <= bus.memDataOut;
        end
        rdStage[0]  <= bus.memReadEnable ? memArray[bus.memReadAddr] : '0;
        eccStage[0] <= bus.memReadEnable && eccArmed;
        rdStage[1]  <= rdStage[0];
        eccStage[1] <= eccStage[0];
        rdStage[2]  <= rdStage[1];
        eccStage[2] <= eccStage[1];
    end
    assign bus.memDataIn    = rdStage[2];
    assign bus.memEccStatus = eccStage[2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboard side: record accepted pushes, compare each popped word with
    // the oldest recorded push, and track the expected occupancy.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("count", 32'(bus.count), 32'(tbCount));
            if (bus.popValid && bus.popReady) begin
                if (sbQueue.size() == 0) begin
                    assertCount++;
                    failCount++;
                    $display("[TB] FAIL popData: got 0x%0h, expected nothing (no word outstanding)", bus.popData);
                end else begin
                    expData = sbQueue.pop_front();
                    checkOutput("popData", 32'(bus.popData), 32'(expData));
                end
                tbCount--;
            end
            if (bus.pushValid && bus.pushReady) begin
                sbQueue.push_back(bus.pushData);
                tbCount++;
            end
        end
    end

    // Hold reset low for lowCycles cycles, checking the reset values while
    // low, then release just after a rising edge.
    task automatic applyReset(input int lowCycles);
        rst_n         = 1'b0;
        bus.pushValid = 1'b0;
        bus.popReady  = 1'b0;
        sbQueue.delete();
        tbCount = 0;
        for (int i = 0; i < lowCycles; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checkOutput("reset pushReady", 32'(bus.pushReady), 0);
                checkOutput("reset popValid", 32'(bus.popValid), 0);
                checkOutput("reset memWriteEnable", 32'(bus.memWriteEnable), 0);
                checkOutput("reset memReadEnable", 32'(bus.memReadEnable), 0);
                checkOutput("reset memWriteAddr", 32'(bus.memWriteAddr), 0);
                checkOutput("reset memReadAddr", 32'(bus.memReadAddr), 0);
                checkOutput("reset count", 32'(bus.count), 0);
                checkOutput("reset eccError", 32'(bus.eccError), 0);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Push nItems sequential words starting at startVal, one attempt per
    // cycle. popMode: 0 = popReady low, 1 = popReady high, 2 = random.
    // Entered and left just after a rising edge.
    task automatic applyStimulus(input int nItems, input int startVal, input int popMode, input int maxCycles);
        int accepted = 0;
        int cycles   = 0;
        bus.pushValid = 1'b1;
        bus.pushData  = WIDTH'(startVal);
        bus.popReady  = (popMode == 2) ? 1'($urandom_range(0, 1)) : (popMode == 1);
        while (accepted < nItems && cycles < maxCycles) begin
            @(negedge clk);
            if (bus.pushReady) begin
                accepted++;
            end
            @(posedge clk);
            #1;
            cycles++;
            bus.pushData = WIDTH'(startVal + accepted);
            if (popMode == 2) begin
                bus.popReady = 1'($urandom_range(0, 1));
            end
        end
        bus.pushValid = 1'b0;
        if (accepted < nItems) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL push timeout: got %0d accepted, expected %0d", accepted, nItems);
        end
    endtask

    // Pop everything left, bounded by maxCycles.
    task automatic drainFifo(input int maxCycles);
        int cycles = 0;
        bus.popReady = 1'b1;
        while (bus.count != '0 && cycles < maxCycles) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("drain count", 32'(bus.count), 0);
        checkOutput("drain popValid", 32'(bus.popValid), 0);
        checkOutput("drain outstanding words", 32'(sbQueue.size()), 0);
    endtask

    // Hard stop in case something wedges the main sequence.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.pushValid = 1'b0;
        bus.pushData  = '0;
        bus.popReady  = 1'b0;
        @(posedge clk);
        #1;
        applyReset(2);

        // Single push: write in cycle 0, read in cycle 2, popValid in cycle 6.
        @(posedge clk);
        #1;
        checkOutput("pushReady after reset", 32'(bus.pushReady), 1);
        bus.popReady  = 1'b1;
        bus.pushValid = 1'b1;
        bus.pushData  = 20'h12345;
        @(negedge clk);
        checkOutput("t1 memWriteEnable", 32'(bus.memWriteEnable), 1);
        checkOutput("t1 memWriteAddr", 32'(bus.memWriteAddr), 0);
        checkOutput("t1 memDataOut", 32'(bus.memDataOut), 32'h12345);
        @(posedge clk);
        #1;
        bus.pushValid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t1 memReadEnable c%0d", c), 32'(bus.memReadEnable), 32'(c == 2));
            if (c == 2) begin
                checkOutput("t1 memReadAddr", 32'(bus.memReadAddr), 0);
            end
            checkOutput($sformatf("t1 popValid c%0d", c), 32'(bus.popValid), 32'(c == 6));
            if (c == 6) begin
                checkOutput("t1 popData", 32'(bus.popData), 32'h12345);
            end
        end
        @(posedge clk);
        #1;

        // Fill with the consumer stalled: 512 in memory plus 4 in the skid.
        applyStimulus(516, 0, 0, 1000);
        checkOutput("fill pushReady", 32'(bus.pushReady), 0);
        checkOutput("fill count", 32'(bus.count), 516);
        bus.pushValid = 1'b1;
        bus.pushData  = 20'd516;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("fill memWriteEnable", 32'(bus.memWriteEnable), 0);
            checkOutput("fill memReadEnable", 32'(bus.memReadEnable), 0);
            @(posedge clk);
            #1;
        end
        bus.pushValid = 1'b0;
        drainFifo(2000);

        // Streaming at one push and one pop per cycle across the pointer wrap:
        // six words stay resident once the pipeline is full.
        applyStimulus(700, 32'h10000, 1, 1000);
        checkOutput("stream count", 32'(bus.count), 6);
        drainFifo(100);

        // Random consumer stalls over 10k words.
        applyStimulus(10000, 32'h20000, 2, 60000);
        drainFifo(3000);

        // ECC status on a returning read: flag sets one cycle later and holds.
        checkOutput("ecc before", 32'(bus.eccError), 0);
        eccArmed      = 1'b1;
        bus.popReady  = 1'b1;
        bus.pushValid = 1'b1;
        bus.pushData  = 20'hABCDE;
        @(posedge clk);
        #1;
        bus.pushValid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("ecc eccError c%0d", c), 32'(bus.eccError), 32'(c >= 6));
            if (c == 6) begin
                checkOutput("ecc popData", 32'(bus.popData), 32'hABCDE);
            end
        end
        eccArmed = 1'b0;
        @(posedge clk);
        #1;

        // Reset with three reads in flight; stale memory data must not pop.
        applyStimulus(3, 32'h30000, 0, 10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        applyReset(1);
        bus.popReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("post-reset popValid", 32'(bus.popValid), 0);
        end
        @(posedge clk);
        #1;

        // Normal operation resumes after the mid-flight reset.
        applyStimulus(1, 32'h4BEEF, 1, 20);
        drainFifo(50);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
